hamming74_codec_unit: RTL and testbench

- Self-contained Hamming(7,4) codec: registered encoder, registered single-error-correcting decoder, and a free-running 3-bit wrap counter.
- Used by the UART datapath: the TX side encodes 4-bit nibbles into 7-bit codewords; the RX side decodes and corrects received codewords.
- The counter provides a 3-bit activity/debug count.

---
 rtl/hamming74_codec_unit.sv | 88 ++++++++
 tb/tb_hamming74_codec_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_codec_unit.sv
// Hamming(7,4) codec: registered encoder, registered single-error-correcting
// decoder with error counter, and a free-running 3-bit wrap counter.
module hamming74_codec_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enc_ena,
   input  logic [3:0] enc_data_in,
   output logic [6:0] enc_code_out,
   output logic       enc_valid_out,
   input  logic       dec_ena,
   input  logic [6:0] dec_in,
   output logic       dec_valid_out,
   output logic [3:0] dec_data_out,
   output logic [2:0] dec_syndrome_out,
   output logic [2:0] dec_err_count_out,
   input  logic       cnt_ena,
   output logic [2:0] cnt_count,
   output logic       cnt_done
);

   logic [6:0] enc_code_nxt;
   logic [2:0] syndrome;
   logic [6:0] flip_mask;
   logic [6:0] corrected;

   always_comb begin
      enc_code_nxt = {enc_data_in[3],
                      enc_data_in[2],
                      enc_data_in[1],
                      enc_data_in[1] ^ enc_data_in[2] ^ enc_data_in[3],
                      enc_data_in[0],
                      enc_data_in[0] ^ enc_data_in[2] ^ enc_data_in[3],
                      enc_data_in[0] ^ enc_data_in[1] ^ enc_data_in[3]};
   end

   // Syndrome value is the 1-based position of a single flipped bit.
   always_comb begin
      syndrome[0] = dec_in[0] ^ dec_in[2] ^ dec_in[4] ^ dec_in[6];
      syndrome[1] = dec_in[1] ^ dec_in[2] ^ dec_in[5] ^ dec_in[6];
      syndrome[2] = dec_in[3] ^ dec_in[4] ^ dec_in[5] ^ dec_in[6];
      flip_mask   = '0;
      if (syndrome != 3'd0) begin
         flip_mask = 7'd1 << (syndrome - 3'd1);
      end
      corrected = dec_in ^ flip_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_code_out  <= '0;
         enc_valid_out <= 1'b0;
      end else begin
         enc_valid_out <= enc_ena;
         if (enc_ena) begin
            enc_code_out <= enc_code_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_valid_out     <= 1'b0;
         dec_data_out      <= '0;
         dec_syndrome_out  <= '0;
         dec_err_count_out <= '0;
      end else begin
         dec_valid_out <= dec_ena;
         if (dec_ena) begin
            dec_data_out     <= {corrected[6], corrected[5], corrected[4], corrected[2]};
            dec_syndrome_out <= syndrome;
            if (syndrome != 3'd0) begin
               dec_err_count_out <= dec_err_count_out + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_count <= '0;
      end else if (cnt_ena) begin
         cnt_count <= cnt_count + 3'd1;
      end
   end

   assign cnt_done = (cnt_count == 3'd7);

endmodule

// File: tb/tb_hamming74_codec_unit.sv
// Scoreboard bench for hamming74_codec_unit: expected encoder/decoder results
// are queued when strobes are driven and compared when the valid pulses appear.
module tb_hamming74_codec_unit;

   logic       clk;
   logic       rst_n;
   logic       enc_ena;
   logic [3:0] enc_data_in;
   logic [6:0] enc_code_out;
   logic       enc_valid_out;
   logic       dec_ena;
   logic [6:0] dec_in;
   logic       dec_valid_out;
   logic [3:0] dec_data_out;
   logic [2:0] dec_syndrome_out;
   logic [2:0] dec_err_count_out;
   logic       cnt_ena;
   logic [2:0] cnt_count;
   logic       cnt_done;

   hamming74_codec_unit dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enc_ena           (enc_ena),
      .enc_data_in       (enc_data_in),
      .enc_code_out      (enc_code_out),
      .enc_valid_out     (enc_valid_out),
      .dec_ena           (dec_ena),
      .dec_in            (dec_in),
      .dec_valid_out     (dec_valid_out),
      .dec_data_out      (dec_data_out),
      .dec_syndrome_out  (dec_syndrome_out),
      .dec_err_count_out (dec_err_count_out),
      .cnt_ena           (cnt_ena),
      .cnt_count         (cnt_count),
      .cnt_done          (cnt_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [6:0] sb_enc[$];
   logic [6:0] sb_dec[$];   // {data[3:0], syndrome[2:0]}

   logic       mon_en = 1'b0;
   logic [6:0] enc_code_m = '0;
   logic [3:0] dec_data_m = '0;
   logic [2:0] dec_syn_m  = '0;
   logic [2:0] dec_err_m  = '0;
   logic [2:0] cnt_m      = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // XOR of the 1-based positions of all set bits; zero for a valid codeword.
   function automatic logic [2:0] ref_syndrome(input logic [6:0] c);
      logic [2:0] s = '0;
      for (int unsigned i = 0; i < 7; i++)
         if (c[i]) s ^= 3'(i + 1);
      return s;
   endfunction

   // Pick the parity triple that zeroes the syndrome.
   function automatic logic [6:0] ref_encode(input logic [3:0] d);
      logic [2:0] p;
      logic [6:0] c;
      for (int unsigned k = 0; k < 8; k++) begin
         p = k[2:0];
         c = {d[3], d[2], d[1], p[2], d[0], p[1], p[0]};
         if (ref_syndrome(c) == 3'd0) return c;
      end
      return '0;
   endfunction

   always @(posedge clk) begin
      logic exp_ev, exp_dv, exp_ce;
      logic [6:0] e;
      if (mon_en) begin
         exp_ev = enc_ena;
         exp_dv = dec_ena;
         exp_ce = cnt_ena;
         #1;
         check_val("enc_valid", enc_valid_out, exp_ev);
         if (exp_ev) begin
            if (sb_enc.size() == 0) check_val("enc_sb_empty", 0, 1);
            else enc_code_m = sb_enc.pop_front();
         end
         check_val("enc_code", enc_code_out, enc_code_m);

         check_val("dec_valid", dec_valid_out, exp_dv);
         if (exp_dv) begin
            if (sb_dec.size() == 0) check_val("dec_sb_empty", 0, 1);
            else begin
               e = sb_dec.pop_front();
               dec_data_m = e[6:3];
               dec_syn_m  = e[2:0];
               if (dec_syn_m != 3'd0) dec_err_m = dec_err_m + 3'd1;
            end
         end
         check_val("dec_data", dec_data_out, dec_data_m);
         check_val("dec_syn", dec_syndrome_out, dec_syn_m);
         check_val("dec_errcnt", dec_err_count_out, dec_err_m);

         if (exp_ce) cnt_m = cnt_m + 3'd1;
         check_val("cnt_count", cnt_count, cnt_m);
         check_val("cnt_done", cnt_done, cnt_m == 3'd7);
      end
   end

   // Called at a negedge; consecutive calls keep the strobe high back-to-back.
   task automatic enc_word(input logic [3:0] d, input logic [6:0] exp_code);
      enc_data_in = d;
      enc_ena     = 1'b1;
      sb_enc.push_back(exp_code);
      @(negedge clk);
      enc_ena = 1'b0;
   endtask

   task automatic dec_word(input logic [6:0] w, input logic [3:0] exp_d, input logic [2:0] exp_s);
      dec_in  = w;
      dec_ena = 1'b1;
      sb_dec.push_back({exp_d, exp_s});
      @(negedge clk);
      dec_ena = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_enc_code"}, enc_code_out, 0);
      check_val({tag, "_enc_valid"}, enc_valid_out, 0);
      check_val({tag, "_dec_valid"}, dec_valid_out, 0);
      check_val({tag, "_dec_data"}, dec_data_out, 0);
      check_val({tag, "_dec_syn"}, dec_syndrome_out, 0);
      check_val({tag, "_dec_err"}, dec_err_count_out, 0);
      check_val({tag, "_cnt"}, cnt_count, 0);
      check_val({tag, "_cnt_done"}, cnt_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] w;
      logic [2:0] err_start;
      rst_n = 1'b0; enc_ena = 1'b0; enc_data_in = '0;
      dec_ena = 1'b0; dec_in = '0; cnt_ena = 1'b0;
      #1;
      check_all_zero("rst_init");
      idle(2);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      idle(1);

      // Encoder: reference vectors, then all nibbles back-to-back.
      enc_word(4'b1011, 7'h55);
      idle(2);
      enc_word(4'h0, 7'h00);
      idle(1);
      enc_word(4'hF, 7'h7F);
      idle(2);
      for (int unsigned n = 0; n < 16; n++) enc_word(4'(n), ref_encode(4'(n)));
      idle(2);

      // Decoder: clean word, single error, hold.
      dec_word(7'h55, 4'hB, 3'd0);
      idle(1);
      dec_word(7'h51, 4'hB, 3'd3);
      idle(3);

      // Every single-bit flip of every codeword.
      for (int unsigned n = 0; n < 16; n++)
         for (int unsigned b = 0; b < 7; b++) begin
            w = ref_encode(4'(n)) ^ (7'd1 << b);
            dec_word(w, 4'(n), 3'(b + 1));
         end
      idle(2);

      // Eight erroneous decodes return the error count to its start value.
      err_start = dec_err_m;
      for (int unsigned k = 0; k < 8; k++) dec_word(7'h55 ^ (7'd1 << (k % 7)), 4'hB, 3'((k % 7) + 1));
      idle(1);
      check_val("dec_err_wrap", dec_err_count_out, err_start);

      // Counter: 8 enabled cycles, then hold.
      cnt_ena = 1'b1;
      idle(8);
      cnt_ena = 1'b0;
      idle(3);
      cnt_ena = 1'b1;
      idle(7);
      cnt_ena = 1'b0;
      idle(2);

      // All three strobes in one cycle.
      enc_data_in = 4'h6; enc_ena = 1'b1; sb_enc.push_back(ref_encode(4'h6));
      dec_in = ref_encode(4'h9) ^ 7'h20; dec_ena = 1'b1; sb_dec.push_back({4'h9, 3'd6});
      cnt_ena = 1'b1;
      @(negedge clk);
      enc_ena = 1'b0; dec_ena = 1'b0; cnt_ena = 1'b0;
      idle(2);
      check_val("sb_enc_drained", sb_enc.size(), 0);
      check_val("sb_dec_drained", sb_dec.size(), 0);

      // Asynchronous reset while counting and decoding.
      mon_en = 1'b0;
      cnt_ena = 1'b1; dec_ena = 1'b1; dec_in = 7'h51; enc_ena = 1'b1; enc_data_in = 4'hF;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_async");
      @(negedge clk);
      cnt_ena = 1'b0; dec_ena = 1'b0; enc_ena = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_hold_cnt", cnt_count, 0);
      cnt_ena = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_resume_cnt", cnt_count, 1);
      cnt_ena = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
